// File: rtl/rr_decoder_arbiter_if.sv
// Handshake bundle between the eight requesters and rr_decoder_arbiter.
// master: arbiter side (drives grants); slave: requester side.
interface rr_decoder_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters driving a 3-to-8 decoded one-hot grant.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decoder_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] grant_r, grant_nx;
  logic       timeout_r, timeout_nx;
  logic [2:0] pick, cand;
  logic       found;
  logic       hold_expired;
  logic       release_now;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Counter is zero whenever IDLE, so it starts at 0 on entry to GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                hold_cnt <= '0;
    else if (state == IDLE) hold_cnt <= '0;
    else                    hold_cnt <= hold_cnt + 8'd1;
  end

  assign hold_expired = (state == GRANT) && (hold_cnt == HOLD_LAST);
`else
  logic unused_hold;
  assign unused_hold  = ^HOLD_LAST;
  assign hold_expired = 1'b0;
`endif

  // First set request searching upward from ptr, wrapping 7 -> 0.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    idx_nx      = idx;
    grant_nx    = grant_r;
    timeout_nx  = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (found) begin
          idx_nx   = pick;
          grant_nx = 8'b1 << pick;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        release_now = bus.done || !bus.req[idx] || hold_expired;
        if (release_now) begin
          grant_nx   = '0;
          ptr_nx     = idx + 3'd1;
          state_nx   = IDLE;
          timeout_nx = hold_expired && !bus.done;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      grant_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      idx       <= idx_nx;
      grant_r   <= grant_nx;
      timeout_r <= timeout_nx;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = idx;
  assign bus.grant_valid = |grant_r;
  assign bus.timeout     = timeout_r;

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter sharing one resource among 8 requesters, built around the 3-to-8 decoder datapath. It selects one requester, registers its 3-bit index and drives the decoded one-hot grant, and holds the grant until the owner releases it. A timeout can optionally force release. It sits in front of any shared 8-way resource whose select lines are driven by the 3-to-8 decoder.

## Interface
- `HOLD_MAX`, default 15: maximum cycles a grant is held before forced release. Range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector; `req[i]` is requester i.
- `done`  in  1  release strobe from the current grantee.
- `grant`  out  8  registered one-hot grant; `grant[i]` means requester i owns the resource.
- `grant_idx`  out  3  binary index of the current grantee; equals the decoder input.
- `grant_valid`  out  1  high while any grant is active; equals `|grant`.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- FSM states:
  - **IDLE**: no grant. If `req != 0`, pick the first set bit searching upward from `ptr`, wrapping 7→0. Load `grant_idx` and set `grant` to the decode of the index. Go to GRANT. Otherwise stay in IDLE.
  - **GRANT**: hold the grant. Release when any of these is true at a clock edge:
    - `done == 1`
    - `req[grant_idx] == 0`
    - the timeout condition is met (see Configuration).
  - On release: clear `grant`, clear `grant_valid`, set `ptr = grant_idx + 1` (mod 8, so 7→0), go to IDLE.
- `grant_idx` keeps its last value in IDLE. `grant` is all zeros in IDLE.
- `grant` is always zero or exactly one-hot, and it always matches `grant_idx` when valid.
- `done` in IDLE is ignored.
- Requests arriving or changing during GRANT do not preempt the grant. Only `req[grant_idx]` is examined in GRANT.
- Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
- `ptr` is 3 bits and not visible on the ports.
- Reset values:
  - `state` = IDLE
  - `ptr` = 0
  - `grant` = 8'h00
  - `grant_idx` = 3'd0
  - `grant_valid` = 0
  - `timeout` = 0
  - hold counter = 0

## Timing
- Request to grant latency: 1 clock. `req` sampled non-zero in IDLE at edge k gives `grant` valid immediately after edge k.
- Release latency: 1 clock. `done` sampled high at edge m gives `grant` = 0 after edge m.
- There is exactly one IDLE cycle between consecutive grants. The earliest next grant is after edge m+1.
- A grant lasts at least 1 cycle.
- `done` must be synchronous to `clk`. It is sampled only at the edge and may be a single-cycle pulse.
- Reset mid-operation: asserting `rst` clears all outputs immediately, without waiting for a clock edge. After `rst` deasserts, arbitration resumes from IDLE with `ptr` = 0.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined**:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches `HOLD_MAX` cycles of grant, the grant is released as a normal release (`ptr` advances).
  - `timeout` pulses high for the 1 cycle following that edge.
  - If `done` arrives at the same edge as the timeout, it is treated as a normal release with no `timeout` pulse.
- **Undefined**:
  - No counter is built. `timeout` is tied to 0.
  - Grants are unbounded.
  - `HOLD_MAX` is ignored.

## Test plan
- Idle: reset, then `req` = 8'h00 for 10 cycles → `grant` = 8'h00, `grant_valid` = 0 and `timeout` = 0 throughout.
- Single request: `req` = 8'h04 → after 1 edge `grant` = 8'h04, `grant_idx` = 2. Pulse `done` for 1 cycle → `grant` = 8'h00 at the next edge. `done` held in IDLE → no effect.
- Fairness and wrap: `req` = 8'hFF held, `done` pulsed in every grant → `grant_idx` sequence 0,1,2,3,4,5,6,7,0 with one IDLE cycle between grants.
- Wrapped search: grant and release idx 5 (`ptr` becomes 6), then `req` = 8'h22 → next grant idx 1 (search 6,7,0,1). After its release, the next grant is idx 5.
- Timeout (macro defined, `HOLD_MAX` = 4): `req` = 8'h08 held, no `done` → `grant` = 8'h08 for exactly 4 cycles, then 8'h00 with `timeout` = 1 for 1 cycle. Re-grant of idx 3 follows after 1 IDLE cycle. With the macro undefined, the grant holds indefinitely.
- Async reset: assert `rst` mid-cycle while `grant` = 8'h40 → `grant`, `grant_valid` and `grant_idx` go to 0 before the next edge. After release of `rst` with `req` = 8'hC0, the first grant is idx 6.
